// File: rtl/maxpool_2x2_row_pair_reader_pkg.sv
// Shared definitions for the 2x2 max-pool row-pair reader.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package maxpool_2x2_row_pair_reader_pkg;

    localparam int LANE_W       = 8;
    localparam int DEF_CHANNELS = 16;
    localparam int DEF_WIDTH    = 512;
    localparam int DEF_HEIGHT   = 256;

    // PRIME runs once after reset to move port B one row ahead of port A
    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_PAIR  = 2'd1,
        ST_SKIP  = 2'd2
    } rd_state_e;

    // Counter width for a range of n values, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/maxpool_2x2_row_pair_reader_max4_lane.sv
// One int8 lane: maximum of four inputs, signed or unsigned ordering.
// Latency: combinational.
// Backpressure: none (pure datapath).
module maxpool_2x2_row_pair_reader_max4_lane
    import maxpool_2x2_row_pair_reader_pkg::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic [LANE_W-1:0] c,
    input  logic [LANE_W-1:0] d,
    output logic [LANE_W-1:0] y
);

    // Flipping the MSB maps two's complement onto an unsigned order, so one comparator serves both modes
    logic [LANE_W-1:0] flip;
    logic [LANE_W-1:0] ka, kb, kc, kd;
    logic [LANE_W-1:0] m_ab, m_cd;

    assign flip = SIGNED ? {1'b1, {(LANE_W-1){1'b0}}} : '0;

    // Two-level compare tree, then undo the MSB flip
    always_comb begin
        ka   = a ^ flip;
        kb   = b ^ flip;
        kc   = c ^ flip;
        kd   = d ^ flip;
        m_ab = (ka > kb) ? ka : kb;
        m_cd = (kc > kd) ? kc : kd;
        y    = ((m_ab > m_cd) ? m_ab : m_cd) ^ flip;
    end

endmodule

// File: rtl/maxpool_2x2_row_pair_reader.sv
// Reads even rows on FIFO port A and odd rows on port B in lockstep; emits one per-channel max per 2x2 window.
// Latency: odd-column issue at t -> o_valid at t+2; peak one pooled pixel every two cycles.
// Backpressure: odd-column pops wait until the output register is free; o_data holds while o_valid & ~o_ready.
module maxpool_2x2_row_pair_reader
    import maxpool_2x2_row_pair_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter bit SIGNED     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_a,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_b,
    input  logic                  fifo_empty_a,
    input  logic                  fifo_empty_b,
    input  logic                  fifo_wr_en,
    output logic                  fifo_rd_en_a,
    output logic                  fifo_rd_en_b,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  o_frame_done
);

    localparam int                COL_W     = cnt_w(WIDTH);
    localparam int                PAIR_W    = cnt_w(HEIGHT / 2);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(HEIGHT / 2 - 1);

    rd_state_e             state, state_nxt;
    logic [COL_W-1:0]      col_cnt, col_cnt_nxt;
    logic [PAIR_W-1:0]     pair_cnt, pair_cnt_nxt;
    logic                  both_rdy, go, is_even, col_last;
    logic                  even_inflight, odd_inflight, last_inflight, o_last;
    logic [DATA_WIDTH-1:0] hold_a, hold_b, max_word;

    // A pop on port A is dropped by the FIFO during a write, so both ports back off together
    assign both_rdy = ~fifo_empty_a & ~fifo_empty_b & ~fifo_wr_en;
    assign is_even  = ~col_cnt[0];
    assign col_last = (col_cnt == COL_LAST);

    // Pop control and next state; every state walks WIDTH words then moves on
    always_comb begin
        state_nxt    = state;
        col_cnt_nxt  = col_cnt;
        pair_cnt_nxt = pair_cnt;
        go           = 1'b0;
        fifo_rd_en_a = 1'b0;
        fifo_rd_en_b = 1'b0;
        case (state)
            ST_PRIME: begin
                go           = ~fifo_empty_b;
                fifo_rd_en_b = go;
            end
            ST_PAIR: begin
                go           = both_rdy & (is_even | ((~o_valid | o_ready) & ~odd_inflight));
                fifo_rd_en_a = go;
                fifo_rd_en_b = go;
            end
            ST_SKIP: begin
                go           = both_rdy;
                fifo_rd_en_a = go;
                fifo_rd_en_b = go;
            end
            default: begin
                state_nxt = ST_PRIME;
            end
        endcase
        if (go) begin
            if (col_last) begin
                col_cnt_nxt = '0;
                case (state)
                    ST_PRIME: state_nxt = ST_PAIR;
                    ST_PAIR:  state_nxt = ST_SKIP;
                    ST_SKIP: begin
                        state_nxt    = ST_PAIR;
                        pair_cnt_nxt = (pair_cnt == PAIR_LAST) ? '0 : pair_cnt + PAIR_W'(1);
                    end
                    default:  state_nxt = ST_PRIME;
                endcase
            end else begin
                col_cnt_nxt = col_cnt + COL_W'(1);
            end
        end
    end

    // State and position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_PRIME;
            col_cnt  <= '0;
            pair_cnt <= '0;
        end else begin
            state    <= state_nxt;
            col_cnt  <= col_cnt_nxt;
            pair_cnt <= pair_cnt_nxt;
        end
    end

    // Tag which kind of column's data arrives from the FIFO next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            even_inflight <= 1'b0;
            odd_inflight  <= 1'b0;
            last_inflight <= 1'b0;
        end else begin
            even_inflight <= go & (state == ST_PAIR) & is_even;
            odd_inflight  <= go & (state == ST_PAIR) & ~is_even;
            last_inflight <= go & (state == ST_PAIR) & col_last & (pair_cnt == PAIR_LAST);
        end
    end

    // Even-column pixels from both rows wait here for their odd-column partners
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_a <= '0;
            hold_b <= '0;
        end else if (even_inflight) begin
            hold_a <= fifo_rd_data_a;
            hold_b <= fifo_rd_data_b;
        end
    end

    // One comparator tree per channel lane
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        maxpool_2x2_row_pair_reader_max4_lane #(
            .SIGNED (SIGNED)
        ) u_max4 (
            .a (hold_a[i*LANE_W +: LANE_W]),
            .b (hold_b[i*LANE_W +: LANE_W]),
            .c (fifo_rd_data_a[i*LANE_W +: LANE_W]),
            .d (fifo_rd_data_b[i*LANE_W +: LANE_W]),
            .y (max_word[i*LANE_W +: LANE_W])
        );
    end

    // Output register: the odd-column gate guarantees it is free whenever a result lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else if (odd_inflight) begin
            o_data  <= max_word;
            o_valid <= 1'b1;
            o_last  <= last_inflight;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

    assign o_frame_done = o_valid & o_ready & o_last;

endmodule

// File: tb/tb_maxpool_2x2_row_pair_reader.sv
// Bench for the 2x2 max-pool reader: dual-read FIFO model, random write/ready timing, scoreboard of window maxima.
// Latency: n/a.
// Backpressure: o_ready driven randomly, with one forced 10-cycle stall.
module tb_maxpool_2x2_row_pair_reader;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int CH   = 2;
    localparam int DW   = CH * 8;
    localparam int FW   = W * H;
    localparam int MAXW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] fifo_rd_data_a, fifo_rd_data_b;
    logic          fifo_empty_a, fifo_empty_b;
    logic          fifo_wr_en = 1'b0;
    logic          fifo_rd_en_a, fifo_rd_en_b;
    logic [DW-1:0] o_data;
    logic          o_valid, o_frame_done;
    logic          o_ready = 1'b0;

    logic [7:0]    ua, ub, uc, ud, uy;

    int checks = 0;
    int errors = 0;

    // FIFO model state: mem holds upstream words, wr_ptr counts words already written
    logic [DW-1:0] mem [MAXW];
    int wr_ptr, ptr_a, ptr_b;
    int stream_len = 0;
    int wr_req = 0;
    int frames = 0;

    // Expected pooled outputs, oldest first
    logic [DW-1:0] exp_dat [$];
    bit            exp_last [$];

    // Stimulus knobs
    int  wr_pct = 70;
    int  ready_pct = 100;
    int  wr_force = 0;
    bit  burst_arm = 0;
    bit  hold_arm = 0;
    bit  hold_pending = 0;
    bit  hold_done = 0;
    int  ready_hold = 0;
    int  hold_ptr = 0;
    bit  held_vld = 0;
    logic [DW-1:0] held_dat = '0;

    always #5 clk = ~clk;

    maxpool_2x2_row_pair_reader #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .WIDTH      (W),
        .HEIGHT     (H),
        .SIGNED     (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_rd_data_a (fifo_rd_data_a),
        .fifo_rd_data_b (fifo_rd_data_b),
        .fifo_empty_a   (fifo_empty_a),
        .fifo_empty_b   (fifo_empty_b),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_rd_en_a   (fifo_rd_en_a),
        .fifo_rd_en_b   (fifo_rd_en_b),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_ready        (o_ready),
        .o_frame_done   (o_frame_done)
    );

    maxpool_2x2_row_pair_reader_max4_lane #(
        .SIGNED (1'b0)
    ) u_lane_u (
        .a (ua),
        .b (ub),
        .c (uc),
        .d (ud),
        .y (uy)
    );

    // Dual-read FIFO: one write stream, two independent read pointers, 1-cycle read latency
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= 0;
            ptr_a          <= 0;
            ptr_b          <= 0;
            fifo_rd_data_a <= '0;
            fifo_rd_data_b <= '0;
        end else begin
            if (fifo_wr_en) wr_ptr <= wr_ptr + 1;
            if (fifo_rd_en_a && !fifo_wr_en && ptr_a < wr_ptr) begin
                fifo_rd_data_a <= mem[ptr_a];
                ptr_a          <= ptr_a + 1;
            end
            if (fifo_rd_en_b && ptr_b < wr_ptr) begin
                fifo_rd_data_b <= mem[ptr_b];
                ptr_b          <= ptr_b + 1;
            end
        end
    end

    assign fifo_empty_a = (ptr_a >= wr_ptr);
    assign fifo_empty_b = (ptr_b >= wr_ptr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Append one frame to the upstream stream and queue its pooled results
    task automatic load_frame(input int kind);
        logic signed [7:0] pix [H][W][CH];
        logic [DW-1:0]     w;
        int                m, v;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int l = 0; l < CH; l++) begin
                    if (kind == 0) pix[r][c][l] = (l == 1) ? 8'(r * W + c) : 8'(-(r * W + c));
                    else           pix[r][c][l] = 8'($urandom);
                end
        if (kind == 2) begin
            for (int l = 0; l < CH; l++) begin
                pix[0][0][l] = -8'sd128;
                pix[0][1][l] = 8'sd127;
                pix[1][0][l] = -8'sd1;
                pix[1][1][l] = 8'sd0;
            end
        end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                w = '0;
                for (int l = 0; l < CH; l++) w[l*8 +: 8] = pix[r][c][l];
                mem[stream_len] = w;
                stream_len++;
            end
        for (int pr = 0; pr < H / 2; pr++)
            for (int pc = 0; pc < W / 2; pc++) begin
                w = '0;
                for (int l = 0; l < CH; l++) begin
                    m = -1000;
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++) begin
                            v = int'(pix[2*pr+dr][2*pc+dc][l]);
                            if (v > m) m = v;
                        end
                    w[l*8 +: 8] = 8'(m);
                end
                exp_dat.push_back(w);
                exp_last.push_back(pr == H / 2 - 1 && pc == W / 2 - 1);
            end
        frames++;
    endtask

    // One cycle: drive inputs at the falling edge, then check what the next rising edge will commit
    task automatic tick();
        logic [DW-1:0] e;
        bit            el;
        @(negedge clk);
        if (hold_arm && o_valid) begin
            hold_arm   = 0;
            ready_hold = 10;
            hold_ptr   = ptr_a;
        end
        if (ready_hold > 0) begin
            o_ready = 1'b0;
            ready_hold--;
            if (ready_hold == 0) hold_pending = 1;
        end else begin
            if (hold_pending) begin
                hold_pending = 0;
                hold_done    = 1;
                check("hold_pops_le_1", 64'((ptr_a - hold_ptr) <= 1), 64'd1);
            end
            o_ready = ($urandom_range(0, 99) < ready_pct);
        end
        if (wr_force > 0 && wr_req < stream_len) begin
            fifo_wr_en = 1'b1;
            wr_force--;
        end else if (burst_arm && wr_req + 3 <= stream_len && !fifo_empty_a && !fifo_empty_b && ptr_b >= W) begin
            burst_arm  = 0;
            wr_force   = 2;
            fifo_wr_en = 1'b1;
        end else begin
            fifo_wr_en = (wr_req < stream_len) && ($urandom_range(0, 99) < wr_pct);
        end
        if (fifo_wr_en) wr_req++;
        #1;
        if (rst_n) begin
            if (fifo_wr_en)   check("a_pop_during_wr", 64'(fifo_rd_en_a), 64'd0);
            if (fifo_empty_a) check("a_pop_empty", 64'(fifo_rd_en_a), 64'd0);
            if (fifo_empty_b) check("b_pop_empty", 64'(fifo_rd_en_b), 64'd0);
            if (ptr_b >= W)   check("lockstep", 64'(fifo_rd_en_b), 64'(fifo_rd_en_a));
            else              check("prime_no_a", 64'(fifo_rd_en_a), 64'd0);
            if (held_vld) begin
                check("o_valid_held", 64'(o_valid), 64'd1);
                check("o_data_stable", 64'(o_data), 64'(held_dat));
            end
            if (o_valid && o_ready) begin
                if (exp_dat.size() == 0) begin
                    check("unexpected_out", 64'(o_data), 64'hdead);
                end else begin
                    e  = exp_dat.pop_front();
                    el = exp_last.pop_front();
                    check("o_data", 64'(o_data), 64'(e));
                    check("frame_done", 64'(o_frame_done), 64'(el));
                end
            end else begin
                check("frame_done_idle", 64'(o_frame_done), 64'd0);
            end
            held_vld = o_valid & ~o_ready;
            held_dat = o_data;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_dat.size() != 0 || wr_req < stream_len) && n < budget) begin
            tick();
            n++;
        end
        check("drain_outstanding", 64'(exp_dat.size()), 64'd0);
        repeat (4) tick();
        check("idle_after_drain", 64'(o_valid), 64'd0);
        // The last SKIP of the latest frame waits for the next frame's row 0, so A trails B by one row
        check("pops_a", 64'(ptr_a), 64'(frames * FW - W));
        check("pops_b", 64'(ptr_b), 64'(frames * FW));
    endtask

    initial begin
        int n;
        int mx;

        // Unsigned lane ordering: 0x80 beats 0x7F when compared without sign
        ua = 8'h80; ub = 8'h7F; uc = 8'h00; ud = 8'h01;
        #1;
        check("lane_unsigned_80", 64'(uy), 64'h80);
        for (int i = 0; i < 6; i++) begin
            ua = 8'($urandom); ub = 8'($urandom); uc = 8'($urandom); ud = 8'($urandom);
            mx = int'(ua);
            if (int'(ub) > mx) mx = int'(ub);
            if (int'(uc) > mx) mx = int'(uc);
            if (int'(ud) > mx) mx = int'(ud);
            #1;
            check("lane_unsigned_rand", 64'(uy), 64'(mx));
        end

        // Reset state
        repeat (3) tick();
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_data", 64'(o_data), 64'd0);
        check("rst_frame_done", 64'(o_frame_done), 64'd0);
        check("rst_rd_en_a", 64'(fifo_rd_en_a), 64'd0);
        check("rst_rd_en_b", 64'(fifo_rd_en_b), 64'd0);
        rst_n = 1'b1;

        // Directed ramp frame: expect {5,0},{7,-2},{13,-8},{15,-10}
        load_frame(0);
        drain(400);

        // Two back-to-back random frames with a write burst and a 10-cycle stall on the first output
        burst_arm = 1;
        hold_arm  = 1;
        ready_pct = 100;
        load_frame(1);
        load_frame(1);
        drain(800);
        check("hold_fired", 64'(hold_done), 64'd1);
        check("burst_fired", 64'(burst_arm), 64'd0);

        // Signed extremes in the first window, random downstream ready
        ready_pct = 50;
        load_frame(2);
        drain(800);

        // Reset while a result is waiting at the output
        ready_pct = 0;
        load_frame(1);
        n = 0;
        while (!o_valid && n < 300) begin
            tick();
            n++;
        end
        check("valid_before_rst", 64'(o_valid), 64'd1);
        rst_n      = 1'b0;
        fifo_wr_en = 1'b0;
        #1;
        check("midrst_o_valid", 64'(o_valid), 64'd0);
        check("midrst_o_data", 64'(o_data), 64'd0);
        check("midrst_frame_done", 64'(o_frame_done), 64'd0);
        exp_dat.delete();
        exp_last.delete();
        stream_len = 0;
        wr_req     = 0;
        frames     = 0;
        wr_force   = 0;
        held_vld   = 0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Clean frame after the mid-frame reset
        ready_pct = 80;
        load_frame(1);
        drain(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
